// File: rtl/pong_pkg.sv
// Shared geometry, derived clamp positions, FSM states and small arithmetic helpers
// for the pong game-state sequencer.
package pong_pkg;

  localparam int H_ACTIVE     = 640;
  localparam int V_ACTIVE     = 480;
  localparam int PADDLE_H     = 64;
  localparam int PADDLE_W     = 8;
  localparam int PADDLE_XL    = 16;
  localparam int PADDLE_XR    = 616;
  localparam int BALL_SZ      = 8;
  localparam int PADDLE_STEP  = 4;
  localparam int BALL_STEP    = 2;
  localparam int SCORE_MAX    = 9;
  localparam int SERVE_FRAMES = 60;

  localparam logic [9:0] V_ACTIVE_W    = 10'(V_ACTIVE);
  localparam logic [9:0] PADDLE_Y0     = 10'(V_ACTIVE / 2 - PADDLE_H / 2);  // 208
  localparam logic [9:0] BALL_X0       = 10'(H_ACTIVE / 2 - BALL_SZ / 2);   // 316
  localparam logic [9:0] BALL_Y0       = 10'(V_ACTIVE / 2 - BALL_SZ / 2);   // 236
  localparam logic [9:0] PADDLE_Y_MAX  = 10'(V_ACTIVE - PADDLE_H);          // 416
  localparam logic [9:0] BALL_Y_MAX    = 10'(V_ACTIVE - BALL_SZ);           // 472
  localparam logic [9:0] BALL_X_MAX    = 10'(H_ACTIVE - BALL_SZ);           // 632
  localparam logic [9:0] HIT_XL        = 10'(PADDLE_XL + PADDLE_W);         // 24
  localparam logic [9:0] HIT_XR        = 10'(PADDLE_XR - BALL_SZ);          // 608
  localparam logic [9:0] PADDLE_XR_END = 10'(PADDLE_XR + PADDLE_W);         // 624
  localparam logic [9:0] P_STEP        = 10'(PADDLE_STEP);
  localparam logic [9:0] B_STEP        = 10'(BALL_STEP);
  localparam logic [3:0] SCORE_MAX_W   = 4'(SCORE_MAX);
  localparam logic [5:0] SERVE_CNT_INIT = 6'(SERVE_FRAMES);

  // A set direction bit always means "towards decreasing coordinate".
  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic DIR_UP    = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PADDLE = 3'd1,
    BALL   = 3'd2,
    HIT    = 3'd3,
    SCORE  = 3'd4,
    SERVE  = 3'd5
  } state_t;

  function automatic logic [9:0] step_clamp(input logic [9:0] pos, input logic neg,
                                            input logic [9:0] lim, input logic [9:0] step);
    logic [10:0] sum;
    sum = {1'b0, pos} + {1'b0, step};
    if (neg) step_clamp = (pos < step) ? 10'd0 : pos - step;
    else     step_clamp = (sum >= {1'b0, lim}) ? lim : sum[9:0];
  endfunction

  function automatic logic at_limit(input logic [9:0] pos, input logic neg,
                                    input logic [9:0] lim, input logic [9:0] step);
    logic [10:0] sum;
    sum = {1'b0, pos} + {1'b0, step};
    at_limit = neg ? (pos < step) : (sum >= {1'b0, lim});
  endfunction

  function automatic logic overlap(input logic [9:0] by, input logic [9:0] py);
    overlap = (({1'b0, by} + 11'(BALL_SZ)) > {1'b0, py}) &&
              ({1'b0, by} < ({1'b0, py} + 11'(PADDLE_H)));
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    sat_inc = (s >= SCORE_MAX_W) ? s : s + 4'd1;
  endfunction

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Signal bundle between the sync generator / buttons / renderer side and the
// pong game-state sequencer.
interface pong_game_ctrl_if;
  logic [9:0] row;
  logic [9:0] col;
  logic       p1_up;
  logic       p1_dn;
  logic       p2_up;
  logic       p2_dn;
  logic [9:0] p1_y;
  logic [9:0] p2_y;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic [3:0] score1;
  logic [3:0] score2;
  logic       game_over;
  logic       busy;

  modport master (
    output row, col, p1_up, p1_dn, p2_up, p2_dn,
    input  p1_y, p2_y, ball_x, ball_y, score1, score2, game_over, busy
  );

  modport slave (
    input  row, col, p1_up, p1_dn, p2_up, p2_dn,
    output p1_y, p2_y, ball_x, ball_y, score1, score2, game_over, busy
  );
endinterface

// File: rtl/paddle_ctrl.sv
// Saturating paddle-position register; moves one step per enabled cycle when
// exactly one of up/dn is pressed.
module paddle_ctrl
  import pong_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       up,
  input  logic       dn,
  output logic [9:0] y
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y <= PADDLE_Y0;
    end else if (en && (up ^ dn)) begin
      y <= step_clamp(y, up, PADDLE_Y_MAX, P_STEP);
    end
  end

endmodule

// File: rtl/pong_game_ctrl.sv
// Per-frame pong state sequencer: paddles, ball, collisions and score once per
// vertical blanking. Optional serve hold is enabled by PONG_SERVE_DELAY_EN.
module pong_game_ctrl
  import pong_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  pong_game_ctrl_if.slave bus
);

  state_t     state;
  state_t     state_nxt;
  logic       frame_tick;
  logic [9:0] p1_y;
  logic [9:0] p2_y;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic       dx;
  logic       dy;
  logic [3:0] score1;
  logic [3:0] score2;
  logic [3:0] score1_inc;
  logic [3:0] score2_inc;
  logic       game_over;
  logic       hit_l;
  logic       hit_r;
  logic       at_left;
  logic       at_right;
`ifdef PONG_SERVE_DELAY_EN
  logic [5:0] serve_cnt;
`endif

  // First cycle of vertical blanking, seen once per frame.
  always_ff @(posedge clk) begin
    if (!rst_n) frame_tick <= 1'b0;
    else        frame_tick <= (bus.row == V_ACTIVE_W) && (bus.col == 10'd0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (frame_tick && !game_over) state_nxt = PADDLE;
`ifdef PONG_SERVE_DELAY_EN
      PADDLE: state_nxt = (serve_cnt != 6'd0) ? IDLE : BALL;
`else
      PADDLE: state_nxt = BALL;
`endif
      BALL:   state_nxt = HIT;
      HIT:    state_nxt = SCORE;
`ifdef PONG_SERVE_DELAY_EN
      SCORE:  state_nxt = (at_left || at_right) ? SERVE : IDLE;
      SERVE:  state_nxt = IDLE;
`else
      SCORE:  state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

`ifdef PONG_SERVE_DELAY_EN
  always_ff @(posedge clk) begin
    if (!rst_n)                                serve_cnt <= 6'd0;
    else if (state == SERVE)                   serve_cnt <= SERVE_CNT_INIT;
    else if (state == PADDLE && serve_cnt != 6'd0) serve_cnt <= serve_cnt - 6'd1;
  end
`endif

  paddle_ctrl u_paddle1 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state == PADDLE),
    .up    (bus.p1_up),
    .dn    (bus.p1_dn),
    .y     (p1_y)
  );

  paddle_ctrl u_paddle2 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state == PADDLE),
    .up    (bus.p2_up),
    .dn    (bus.p2_dn),
    .y     (p2_y)
  );

  always_comb begin
    hit_l = (dx == DIR_LEFT) && (ball_x <= HIT_XL) &&
            (({1'b0, ball_x} + 11'(BALL_SZ)) > 11'(PADDLE_XL)) && overlap(ball_y, p1_y);
    hit_r = (dx == DIR_RIGHT) && (({1'b0, ball_x} + 11'(BALL_SZ)) >= 11'(PADDLE_XR)) &&
            (ball_x < PADDLE_XR_END) && overlap(ball_y, p2_y);
  end

  assign at_left    = (ball_x == 10'd0);
  assign at_right   = (ball_x == BALL_X_MAX);
  assign score1_inc = sat_inc(score1);
  assign score2_inc = sat_inc(score2);

  // Ball, direction and score updates; a paddle bounce moves the ball off the
  // goal columns, so HIT naturally wins over SCORE in the same frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ball_x    <= BALL_X0;
      ball_y    <= BALL_Y0;
      dx        <= DIR_RIGHT;
      dy        <= DIR_DOWN;
      score1    <= 4'd0;
      score2    <= 4'd0;
      game_over <= 1'b0;
    end else begin
      case (state)
        BALL: begin
          ball_x <= step_clamp(ball_x, dx, BALL_X_MAX, B_STEP);
          ball_y <= step_clamp(ball_y, dy, BALL_Y_MAX, B_STEP);
          if (at_limit(ball_y, dy, BALL_Y_MAX, B_STEP)) dy <= ~dy;
        end
        HIT: begin
          if (hit_l) begin
            ball_x <= HIT_XL;
            dx     <= DIR_RIGHT;
          end else if (hit_r) begin
            ball_x <= HIT_XR;
            dx     <= DIR_LEFT;
          end
        end
        SCORE: begin
          if (at_left) begin
            score2 <= score2_inc;
            dx     <= DIR_LEFT;
            ball_x <= BALL_X0;
            ball_y <= BALL_Y0;
            dy     <= DIR_DOWN;
            if (score2_inc == SCORE_MAX_W) game_over <= 1'b1;
          end else if (at_right) begin
            score1 <= score1_inc;
            dx     <= DIR_RIGHT;
            ball_x <= BALL_X0;
            ball_y <= BALL_Y0;
            dy     <= DIR_DOWN;
            if (score1_inc == SCORE_MAX_W) game_over <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.p1_y      = p1_y;
  assign bus.p2_y      = p2_y;
  assign bus.ball_x    = ball_x;
  assign bus.ball_y    = ball_y;
  assign bus.score1    = score1;
  assign bus.score2    = score2;
  assign bus.game_over = game_over;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Randomized bench for pong_game_ctrl: compressed frames driven on row/col,
// every frame checked against a behavioural game model.
module tb_pong_game_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pong_game_ctrl_if bus();

  pong_game_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural game model
  int m_p1, m_p2, m_bx, m_by, m_s1, m_s2;
  bit m_left, m_up, m_go;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_p1 = 208; m_p2 = 208; m_bx = 316; m_by = 236;
    m_left = 0; m_up = 0; m_s1 = 0; m_s2 = 0; m_go = 0;
  endtask

  function automatic int pad_move(input int y, input bit u, input bit d);
    if (u && !d) return (y < 4) ? 0 : y - 4;
    if (d && !u) return (y + 4 > 416) ? 416 : y + 4;
    return y;
  endfunction

  function automatic bit vert_hit(input int by, input int py);
    return (by + 8 > py) && (by < py + 64);
  endfunction

  task automatic model_frame(input bit u1, input bit d1, input bit u2, input bit d2);
    if (!m_go) begin
      m_p1 = pad_move(m_p1, u1, d1);
      m_p2 = pad_move(m_p2, u2, d2);
      if (m_up) begin
        if (m_by < 2) begin m_by = 0; m_up = 0; end else m_by -= 2;
      end else begin
        if (m_by + 2 >= 472) begin m_by = 472; m_up = 1; end else m_by += 2;
      end
      if (m_left) m_bx = (m_bx < 2) ? 0 : m_bx - 2;
      else        m_bx = (m_bx + 2 >= 632) ? 632 : m_bx + 2;
      if (m_left && m_bx <= 24 && m_bx + 8 > 16 && vert_hit(m_by, m_p1)) begin
        m_bx = 24; m_left = 0;
      end else if (!m_left && m_bx + 8 >= 616 && m_bx < 624 && vert_hit(m_by, m_p2)) begin
        m_bx = 608; m_left = 1;
      end else if (m_bx == 0) begin
        m_s2 = (m_s2 < 9) ? m_s2 + 1 : 9;
        m_left = 1; m_bx = 316; m_by = 236; m_up = 0;
      end else if (m_bx == 632) begin
        m_s1 = (m_s1 < 9) ? m_s1 + 1 : 9;
        m_left = 0; m_bx = 316; m_by = 236; m_up = 0;
      end
      m_go = (m_s1 == 9) || (m_s2 == 9);
    end
  endtask

  task automatic check_all(input string tag);
    check_val({tag, ":p1_y"},      int'(bus.p1_y),      m_p1);
    check_val({tag, ":p2_y"},      int'(bus.p2_y),      m_p2);
    check_val({tag, ":ball_x"},    int'(bus.ball_x),    m_bx);
    check_val({tag, ":ball_y"},    int'(bus.ball_y),    m_by);
    check_val({tag, ":score1"},    int'(bus.score1),    m_s1);
    check_val({tag, ":score2"},    int'(bus.score2),    m_s2);
    check_val({tag, ":game_over"}, int'(bus.game_over), int'(m_go));
  endtask

  // One compressed frame: blanking start, seven blanking cycles, one visible cycle.
  task automatic run_frame(input bit u1, input bit d1, input bit u2, input bit d2,
                           output int busy_cnt);
    @(negedge clk);
    bus.row = 10'd480; bus.col = 10'd0;
    bus.p1_up = u1; bus.p1_dn = d1; bus.p2_up = u2; bus.p2_dn = d2;
    busy_cnt = 0;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      busy_cnt += int'(bus.busy);
      bus.col = 10'(i);
    end
    @(negedge clk);
    busy_cnt += int'(bus.busy);
    bus.row = 10'($urandom_range(0, 479));
    bus.col = 10'($urandom_range(0, 639));
    @(negedge clk);
    busy_cnt += int'(bus.busy);
  endtask

  task automatic frame_and_check(input string tag, input bit u1, input bit d1,
                                 input bit u2, input bit d2);
    int  bc;
    bit  was_go;
    was_go = m_go;
    run_frame(u1, d1, u2, d2, bc);
    model_frame(u1, d1, u2, d2);
    check_all(tag);
    check_val({tag, ":busy_cycles"}, bc, was_go ? 0 : 4);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int post_go;
    bit u1, d1, u2, d2;

    rst_n = 1'b0;
    bus.row = 10'd0; bus.col = 10'd0;
    bus.p1_up = 1'b0; bus.p1_dn = 1'b0; bus.p2_up = 1'b0; bus.p2_dn = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
    check_all("reset");
    check_val("reset:busy", int'(bus.busy), 0);
    rst_n = 1'b1;

    frame_and_check("idle1", 0, 0, 0, 0);
    frame_and_check("idle2", 0, 0, 0, 0);
    check_val("idle2:ball_x_abs", int'(bus.ball_x), 320);
    check_val("idle2:ball_y_abs", int'(bus.ball_y), 240);

    // Long random game, paddles drifting upward, until a win plus three frozen frames.
    post_go = 0;
    for (int f = 0; f < 6000 && post_go < 4; f++) begin
      u1 = 1'($urandom_range(0, 1));
      d1 = ($urandom_range(0, 3) == 0);
      u2 = 1'($urandom_range(0, 1));
      d2 = ($urandom_range(0, 3) == 0);
      frame_and_check("rand", u1, d1, u2, d2);
      if (m_go) post_go++;
    end

    // Reset clears a finished game; then abort a frame during the BALL cycle.
    apply_reset();
    check_all("rst2");
    for (int f = 0; f < 3; f++) frame_and_check("post_rst", 1, 0, 0, 1);
    @(negedge clk);
    bus.row = 10'd480; bus.col = 10'd0;
    bus.p1_up = 1'b1; bus.p1_dn = 1'b0; bus.p2_up = 1'b0; bus.p2_dn = 1'b1;
    @(negedge clk);
    bus.col = 10'd1;
    @(negedge clk);
    check_val("abort:busy_in_paddle", int'(bus.busy), 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    model_reset();
    check_all("abort");
    check_val("abort:busy", int'(bus.busy), 0);
    rst_n = 1'b1;
    frame_and_check("after_abort", 0, 0, 0, 0);
    check_val("after_abort:ball_x_abs", int'(bus.ball_x), 318);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
